// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS control slice: instruction
// field encodings, ALU operation codes, datapath mux selects and FSM state
// codes.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operations
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_LUI = 4'b1010;

  // Datapath mux selects
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic       ALUA_PC  = 1'b0;
  localparam logic       ALUA_RS  = 1'b1;
  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  // FSM state codes
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_EXEC_R = 4'd2;
  localparam logic [3:0] S_EXEC_I = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_MEM_RD = 4'd5;
  localparam logic [3:0] S_MEM_WR = 4'd6;
  localparam logic [3:0] S_WB_R   = 4'd7;
  localparam logic [3:0] S_WB_I   = 4'd8;
  localparam logic [3:0] S_WB_MEM = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;
  localparam logic [3:0] S_JR     = 4'd13;
  localparam logic [3:0] S_TRAP   = 4'd14;

  // DECODE dispatch: first execute state for an opcode/funct pair,
  // S_TRAP for anything the core does not implement.
  function automatic logic [3:0] decode_dispatch(input logic [5:0] opcode,
                                                 input logic [5:0] fn);
    logic [3:0] ns;
    ns = S_TRAP;
    case (opcode)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR,
          FN_SLT, FN_SLL, FN_SRL:          ns = S_EXEC_R;
          FN_JR:                           ns = S_JR;
          default:                         ns = S_TRAP;
        endcase
      end
      OP_LW, OP_SW:                        ns = S_ADDR;
      OP_BEQ, OP_BNE:                      ns = S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI,
      OP_SLTI, OP_LUI:                     ns = S_EXEC_I;
      OP_J:                                ns = S_JUMP;
      OP_JAL:                              ns = S_JAL;
      default:                             ns = S_TRAP;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control <-> datapath bundle for the multi-cycle MIPS core.
// Memory handshake: while mem_read or mem_write is high the request is
// outstanding; the access completes on the cycle mem_ready is sampled high,
// and the strobe, i_or_d and address source stay constant until then.
// mem_ready is ignored whenever no request strobe is active.
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic [5:0] fn;
  logic       mem_ready;
  logic       zero;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] wb_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_ctrl;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;   // debug view of the control FSM

  modport master (
    input  opcode, fn, mem_ready, zero,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
           reg_write, reg_dst, wb_src, alu_src_a, alu_src_b, alu_ctrl,
           instr_done, illegal, state
  );

  modport slave (
    output opcode, fn, mem_ready, zero,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
           reg_write, reg_dst, wb_src, alu_src_a, alu_src_b, alu_ctrl,
           instr_done, illegal, state
  );
endinterface

// File: rtl/mips_alu_control.sv
// ALU operation select: PC/address arithmetic uses ADD, branches compare
// with SUB, R-type ops follow funct and I-type ops follow opcode.
module mips_alu_control
  import mips_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic [5:0] fn,
  output logic [3:0] alu_ctrl
);

  // Pick the ALU operation for the current state class
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (state)
      S_EXEC_R: begin
        case (fn)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          FN_SLL:  alu_ctrl = ALU_SLL;
          FN_SRL:  alu_ctrl = ALU_SRL;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      S_EXEC_I: begin
        case (opcode)
          OP_ADDI: alu_ctrl = ALU_ADD;
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORI:  alu_ctrl = ALU_OR;
          OP_SLTI: alu_ctrl = ALU_SLT;
          OP_LUI:  alu_ctrl = ALU_LUI;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      S_BRANCH: alu_ctrl = ALU_SUB;
      default:  alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback
// over the shared datapath and drives every enable and mux select.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  mips_multicycle_control_if.master   bus
);

  logic [3:0] state;
  logic [3:0] next_state;
  logic       illegal_q;

  mips_alu_control u_alu_control (
    .state    (state),
    .opcode   (bus.opcode),
    .fn       (bus.fn),
    .alu_ctrl (bus.alu_ctrl)
  );

  assign bus.state   = state;
  assign bus.illegal = illegal_q;

  // State register; reset lands in FETCH without needing a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next_state;
  end

  // Sticky illegal flag, set when DECODE dispatches to TRAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           illegal_q <= 1'b0;
    else if (state == S_DECODE && next_state == S_TRAP) illegal_q <= 1'b1;
  end

  // Next-state logic; memory states wait for mem_ready
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (bus.mem_ready) next_state = S_DECODE;
      S_DECODE: next_state = decode_dispatch(bus.opcode, bus.fn);
      S_EXEC_R: next_state = S_WB_R;
      S_EXEC_I: next_state = S_WB_I;
      S_ADDR:   next_state = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (bus.mem_ready) next_state = S_WB_MEM;
      S_MEM_WR: if (bus.mem_ready) next_state = S_FETCH;
      S_WB_R, S_WB_I, S_WB_MEM,
      S_BRANCH, S_JUMP, S_JAL, S_JR: next_state = S_FETCH;
      S_TRAP:   next_state = S_TRAP;
      default:  next_state = S_FETCH;
    endcase
  end

  // Datapath controls from state; everything forced low while rst is high
  // so an abandoned instruction can never leave a partial write behind.
  always_comb begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = PC_SRC_ALU;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = REG_DST_RT;
    bus.wb_src     = WB_ALUOUT;
    bus.alu_src_a  = ALUA_PC;
    bus.alu_src_b  = ALUB_RT;
    bus.instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = ALUB_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: bus.alu_src_b = ALUB_IMM_SH;
      S_EXEC_R: bus.alu_src_a = ALUA_RS;
      S_EXEC_I, S_ADDR: begin
        bus.alu_src_a = ALUA_RS;
        bus.alu_src_b = ALUB_IMM;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_WB_R: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = REG_DST_RD;
        bus.instr_done = 1'b1;
      end
      S_WB_I: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.wb_src     = WB_MDR;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a  = ALUA_RS;
        bus.pc_src     = PC_SRC_ALUOUT;
        bus.pc_write   = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_src     = PC_SRC_JUMP;
        bus.instr_done = 1'b1;
      end
      S_JAL: begin
        bus.pc_write   = 1'b1;
        bus.pc_src     = PC_SRC_JUMP;
        bus.reg_write  = 1'b1;
        bus.reg_dst    = REG_DST_RA;
        bus.wb_src     = WB_PC;
        bus.instr_done = 1'b1;
      end
      S_JR: begin
        bus.pc_write   = 1'b1;
        bus.pc_src     = PC_SRC_RS;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.i_or_d     = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = PC_SRC_ALU;
      bus.reg_write  = 1'b0;
      bus.reg_dst    = REG_DST_RT;
      bus.wb_src     = WB_ALUOUT;
      bus.alu_src_a  = ALUA_PC;
      bus.alu_src_b  = ALUB_RT;
      bus.instr_done = 1'b0;
    end
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle control FSM for the MIPS core. Consumes the opcode/funct fields split out of the instruction register by the field decoder and sequences the shared datapath (PC, IR, single memory port, register file, one ALU) through fetch/decode/execute/memory/writeback. Emits every datapath enable and mux select. Stalls on a single memory ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26] from field decoder (IR-driven, stable after FETCH)
- fn  in  6  instr[5:0] from field decoder
- mem_ready  in  1  memory access complete this cycle
- zero  in  1  ALU zero flag
- mem_read / mem_write  out  1  memory request strobes
- i_or_d  out  1  0 = address from PC, 1 = from ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  unconditional PC load
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],instr[25:0],00}, 11 rs
- reg_write  out  1  register-file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- wb_src  out  2  00 ALUOut, 01 MDR, 10 PC
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_ctrl  out  4  ALU operation
- instr_done  out  1  one-cycle pulse on last cycle of each instruction
- illegal  out  1  sticky, unsupported opcode/funct seen

## Operation
- Supported: R-type (fn add 20h, sub 22h, and 24h, or 25h, slt 2Ah, sll 00h, srl 02h, jr 08h); lw 23h, sw 2Bh, beq 04h, bne 05h, addi 08h, andi 0Ch, ori 0Dh, slti 0Ah, lui 0Fh, j 02h, jal 03h.
- alu_ctrl: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1001, LUI 1010.
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, JAL, JR, TRAP.
- FETCH: mem_read=1, i_or_d=0, alu PC+4 (a=0, b=01, ADD). Hold until mem_ready; on mem_ready cycle ir_write=1, pc_write=1, pc_src=00, -> DECODE.
- DECODE: alu a=0, b=11, ADD (branch target to ALUOut). Dispatch on opcode/fn; unsupported -> TRAP.
- EXEC_R: a=1, b=00, alu_ctrl from fn -> WB_R (reg_dst=01, wb_src=00, reg_write).
- EXEC_I: a=1, b=10, op per opcode (andi/ori zero-extension handled by datapath) -> WB_I (reg_dst=00, wb_src=00).
- ADDR: a=1, b=10, ADD; lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD/MEM_WR: i_or_d=1, strobe held until mem_ready; MEM_RD -> WB_MEM (reg_dst=00, wb_src=01); MEM_WR -> FETCH.
- BRANCH: a=1, b=00, SUB, pc_src=01; pc_write = zero (beq) or !zero (bne).
- JUMP: pc_write, pc_src=10. JAL: pc_write, pc_src=10, reg_write, reg_dst=10, wb_src=10. JR: pc_write, pc_src=11.
- All writeback/branch/jump states and MEM_WR-on-ready -> FETCH with instr_done=1.
- TRAP: all strobes 0, illegal=1, stay until reset.

## Timing
- Outputs combinational from state (plus opcode/fn, zero, mem_ready where stated); state registered.
- Reset: state FETCH, illegal=0; no clock needed for reset to take effect. While rst high every strobe is 0.
- Zero-wait latency (mem_ready high on first request cycle): R/I-type 4, lw 5, sw 4, beq/bne/j/jal/jr 3 cycles.
- Each mem_ready low cycle in FETCH/MEM_RD/MEM_WR adds exactly one cycle; strobes and i_or_d stay constant while waiting.
- mem_ready outside memory states ignored.
- Reset mid-instruction abandons it; no partial register/PC write after rst deasserts.

## Structure
- mips_pkg: opcode and funct constants, alu_ctrl encodings, pc_src/reg_dst/wb_src/alu_src_b encodings, state enum.
- Sub-module mips_alu_control: combinational (state class, opcode, fn) -> alu_ctrl.

## Test plan
- Reset then add (opcode 0, fn 20h), mem_ready always 1 -> states FETCH,DECODE,EXEC_R,WB_R; reg_write, reg_dst=01 in cycle 4; instr_done cycle 4.
- lw with mem_ready low 2 cycles in MEM_RD -> 7 cycles total, mem_read/i_or_d=1 held 3 cycles, wb_src=01 at writeback.
- beq zero=1 -> pc_write=1 in BRANCH; bne zero=1 -> pc_write=0; both 3 cycles.
- jal -> cycle 3: pc_write, pc_src=10, reg_write, reg_dst=10, wb_src=10.
- opcode 3Fh -> TRAP, illegal=1 sticky, no strobes for 10 cycles; rst clears.
- rst asserted mid MEM_WR -> mem_write drops asynchronously; after release FETCH with mem_read=1.
